// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 instruction-fetch front end.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, inst} words; clr empties it in one edge.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
    push |-> (count < CW'(DEPTH)));

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues IMEM reads against queue credit and
// buffers returning words for decode; redirects flush the queue and in-flight reads.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  int              IM_AW    = 14,
  parameter  int              DEPTH    = 4,
  parameter  int              RD_LAT   = 1,
  parameter  logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      DO_im,
  output logic [IM_AW-1:0] A_im,
  output logic             OE_im,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_inst,
  output logic [XLEN-1:0]  id_pc,
  output logic [CW-1:0]    q_count
);

  localparam int IW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(DEPTH + RD_LAT + 1);

  logic [XLEN-1:0]   fpc;
  logic              epoch;
  logic [RD_LAT-1:0] slot_valid;
  logic [RD_LAT-1:0] slot_ep;
  logic [XLEN-1:0]   slot_pc [RD_LAT];
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     count;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              unused_bits;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(slot_valid[i]);
  end

  // Credit excludes a same-cycle pop so a push can never land on a full queue.
  assign issue = !rst && !redirect_valid && ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
  assign push  = !rst && !redirect_valid && slot_valid[RD_LAT-1] && (slot_ep[RD_LAT-1] == epoch);
  assign pop   = id_valid && id_ready && !redirect_valid;

  assign push_entry = '{pc: slot_pc[RD_LAT-1], inst: DO_im};

  assign OE_im    = issue;
  assign A_im     = rst ? RESET_PC[IM_AW+1:2] : fpc[IM_AW+1:2];
  assign id_valid = !rst && (count != '0);
  assign id_inst  = id_valid ? head.inst : '0;
  assign id_pc    = id_valid ? head.pc : '0;
  assign q_count  = rst ? '0 : count;

  // Redirect also kills the tracking slots: two redirects in a row toggle the
  // 1-bit epoch back, so epoch alone could let a pre-redirect read through.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc        <= RESET_PC;
      epoch      <= 1'b0;
      slot_valid <= '0;
    end else if (redirect_valid) begin
      fpc        <= {redirect_pc[XLEN-1:2], 2'b00};
      epoch      <= ~epoch;
      slot_valid <= '0;
    end else begin
      if (issue) fpc <= fpc + XLEN'(4);
      slot_valid[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) slot_valid[i] <= slot_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    slot_pc[0] <= fpc;
    slot_ep[0] <= epoch;
    for (int i = 1; i < RD_LAT; i++) begin
      slot_pc[i] <= slot_pc[i-1];
      slot_ep[i] <= slot_ep[i-1];
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign unused_bits = ^{redirect_pc[1:0], fpc[XLEN-1:IM_AW+2], fpc[1:0]};

endmodule
